// File: rtl/multicycle_control_unit.sv
// Moore-FSM control unit for the multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, handles memory wait states and traps illegal opcodes.
module multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  mem_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_srcA,
    output logic [1:0]            alu_srcB,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_op,
    output logic [3:0]            state
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR  = 4'd6,  S_EXECI   = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH  = 4'd9,  S_JAL    = 4'd10, S_JALR    = 4'd11,
        S_JALRL    = 4'd12, S_LUI     = 4'd13, S_AUIPC  = 4'd14, S_TRAP    = 4'd15
    } state_t;

    state_t     cur, nxt;
    logic       ready;
    logic       taken;
    logic [3:0] exec_alu, alu_op;
    logic       mem_req_c, ir_write_c, mem_write_c, pc_write_c, reg_write_c;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    // Branch condition from funct3 and the ALU compare flags.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    // Execute-stage ALU op; sub only exists for register-register adds.
    always_comb begin
        exec_alu = ALU_ADD;
        case (funct3)
            3'b000: exec_alu = (cur == S_EXECR && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: exec_alu = ALU_SLL;
            3'b010: exec_alu = ALU_SLT;
            3'b011: exec_alu = ALU_SLTU;
            3'b100: exec_alu = ALU_XOR;
            3'b101: exec_alu = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: exec_alu = ALU_OR;
            3'b111: exec_alu = ALU_AND;
            default: exec_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:         imm_src = 3'b001;
            OP_BR:            imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    always_comb begin
        nxt         = cur;
        mem_req_c   = 1'b0;
        adr_src     = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        result_src  = RES_ALUOUT;
        alu_srcA    = SRCA_PC;
        alu_srcB    = SRCB_RD2;
        alu_op      = ALU_ADD;
        illegal_op  = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_srcB   = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write_c = ready;
                pc_write_c = ready;
                if (ready) nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_srcA = SRCA_OLDPC;
                alu_srcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R:              nxt = S_EXECR;
                    OP_I:              nxt = S_EXECI;
                    OP_BR:             nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR;
                    OP_LUI:            nxt = S_LUI;
                    OP_AUIPC:          nxt = S_AUIPC;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_srcA = SRCA_RD1;
                alu_srcB = SRCB_IMM;
                nxt      = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_c = 1'b1;
                nxt         = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (ready) nxt = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_srcA = SRCA_RD1;
                alu_srcB = (cur == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_op   = exec_alu;
                nxt      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                nxt         = S_FETCH;
            end
            S_BRANCH: begin
                alu_srcA   = SRCA_RD1;
                alu_op     = ALU_SUB;
                pc_write_c = taken;
                nxt        = S_FETCH;
            end
            S_JAL: begin
                alu_srcA   = SRCA_OLDPC;
                alu_srcB   = SRCB_FOUR;
                pc_write_c = 1'b1;
                nxt        = S_ALUWB;
            end
            S_JALR: begin
                alu_srcA   = SRCA_RD1;
                alu_srcB   = SRCB_IMM;
                result_src = RES_ALU;
                pc_write_c = 1'b1;
                nxt        = S_JALRL;
            end
            S_JALRL: begin
                alu_srcA    = SRCA_OLDPC;
                alu_srcB    = SRCB_FOUR;
                result_src  = RES_ALU;
                reg_write_c = 1'b1;
                nxt         = S_FETCH;
            end
            S_LUI: begin
                alu_srcA = SRCA_ZERO;
                alu_srcB = SRCB_IMM;
                nxt      = S_ALUWB;
            end
            S_AUIPC: begin
                alu_srcA = SRCA_OLDPC;
                alu_srcB = SRCB_IMM;
                nxt      = S_ALUWB;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                nxt        = S_TRAP;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Enables are forced low for the whole time reset is asserted.
    assign mem_req     = rst_n & mem_req_c;
    assign ir_write    = rst_n & ir_write_c;
    assign mem_write   = rst_n & mem_write_c;
    assign pc_write    = rst_n & pc_write_c;
    assign reg_write   = rst_n & reg_write_c;
    assign alu_control = ALU_CTRL_W'(alu_op);
    assign state       = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded into an
// expected per-cycle trace (state plus control word) from the instruction-level rules.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7_5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
    logic       mem_req, adr_src, ir_write, mem_write, pc_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_srcA, alu_srcB;
    logic [2:0] imm_src;
    logic [3:0] alu_control, state;

    multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
        .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .imm_src(imm_src),
        .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        rdy;
        logic [19:0] ctl;
    } step_t;

    step_t      q[$];
    int         tests = 0;
    int         failures = 0;
    logic [2:0] imm_e;
    logic [19:0] obs;

    assign obs = {mem_req, adr_src, ir_write, mem_write, pc_write, reg_write,
                  result_src, alu_srcA, alu_srcB, imm_src, alu_control, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] ctl(input logic mreq, input logic adr, input logic irw,
                                        input logic mw, input logic pcw, input logic rw,
                                        input logic [1:0] rs, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [3:0] alu,
                                        input logic ill);
        return {mreq, adr, irw, mw, pcw, rw, rs, sa, sb, imm_e, alu, ill};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f75, input logic is_r);
        case (f3)
            3'd0: return (is_r && f75) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f75 ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input int st, input logic rdy, input logic [19:0] c);
        q.push_back({4'(st), rdy, c});
    endtask

    // Instruction classes: 0 lw,1 sw,2 R,3 I,4 branch,5 jal,6 jalr,7 lui,8 auipc,9 illegal
    task automatic build(input int cls, input logic [2:0] f3, input logic f75, input logic z,
                         input logic l, input logic lu, input int fw, input int mw);
        logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        logic [2:0] imms [10] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd0, 3'd4, 3'd4, 3'd0};
        q.delete();
        op = ops[cls]; funct3 = f3; funct7_5 = f75; zero = z; lt = l; ltu = lu;
        imm_e = imms[cls];
        for (int i = 0; i < fw; i++) push(0, 1'b0, ctl(1,0,0,0,0,0, 2'd2, 2'd0, 2'd2, 4'd0, 0));
        push(0, 1'b1, ctl(1,0,1,0,1,0, 2'd2, 2'd0, 2'd2, 4'd0, 0));
        push(1, rnd(), ctl(0,0,0,0,0,0, 2'd0, 2'd1, 2'd1, 4'd0, 0));
        case (cls)
            0, 1: begin
                push(2, rnd(), ctl(0,0,0,0,0,0, 2'd0, 2'd2, 2'd1, 4'd0, 0));
                for (int i = 0; i <= mw; i++)
                    push(cls == 0 ? 3 : 5, i == mw, ctl(1,1,0,cls == 1,0,0, 2'd0, 2'd0, 2'd0, 4'd0, 0));
                if (cls == 0) push(4, rnd(), ctl(0,0,0,0,0,1, 2'd1, 2'd0, 2'd0, 4'd0, 0));
            end
            2, 3: begin
                push(cls == 2 ? 6 : 7, rnd(),
                     ctl(0,0,0,0,0,0, 2'd0, 2'd2, cls == 2 ? 2'd0 : 2'd1, exp_alu(f3, f75, cls == 2), 0));
                push(8, rnd(), ctl(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 4'd0, 0));
            end
            4: push(9, rnd(), ctl(0,0,0,0,br_taken(f3, z, l, lu),0, 2'd0, 2'd2, 2'd0, 4'd1, 0));
            5: begin
                push(10, rnd(), ctl(0,0,0,0,1,0, 2'd0, 2'd1, 2'd2, 4'd0, 0));
                push(8, rnd(), ctl(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 4'd0, 0));
            end
            6: begin
                push(11, rnd(), ctl(0,0,0,0,1,0, 2'd2, 2'd2, 2'd1, 4'd0, 0));
                push(12, rnd(), ctl(0,0,0,0,0,1, 2'd2, 2'd1, 2'd2, 4'd0, 0));
            end
            7, 8: begin
                push(cls == 7 ? 13 : 14, rnd(), ctl(0,0,0,0,0,0, 2'd0, cls == 7 ? 2'd3 : 2'd1, 2'd1, 4'd0, 0));
                push(8, rnd(), ctl(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 4'd0, 0));
            end
            default: for (int i = 0; i < 20; i++) push(15, rnd(), ctl(0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 4'd0, 1));
        endcase
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic play(input string name);
        int n = 0;
        foreach (q[i]) begin
            @(negedge clk);
            mem_ready = q[i].rdy;
            #1;
            check($sformatf("%s_c%0d_state", name, n), 32'(state), 32'(q[i].st));
            check($sformatf("%s_c%0d_ctl", name, n), 32'(obs), 32'(q[i].ctl));
            n++;
        end
    endtask

    task automatic run(input string name, input int cls, input logic [2:0] f3, input logic f75,
                       input logic z, input logic l, input logic lu, input int fw, input int mw);
        build(cls, f3, f75, z, l, lu, fw, mw);
        play(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_enables", 32'({mem_req, ir_write, mem_write, pc_write, reg_write, illegal_op}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("add",  2, 3'd0, 1'b0, 0, 0, 0, 0, 0);
        run("sub",  2, 3'd0, 1'b1, 0, 0, 0, 0, 0);
        run("lw",   0, 3'd2, 1'b0, 0, 0, 0, 3, 2);
        run("bne",  4, 3'd1, 1'b0, 1, 0, 0, 0, 0);
        run("blt",  4, 3'd4, 1'b0, 0, 1, 0, 0, 0);
        run("bgeu", 4, 3'd7, 1'b0, 0, 0, 0, 0, 0);
        run("jalr", 6, 3'd0, 1'b0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 150; k++)
            run($sformatf("rnd%0d", k), $urandom_range(0, 8), 3'($urandom_range(0, 7)),
                rnd(), rnd(), rnd(), rnd(), $urandom_range(0, 3), $urandom_range(0, 3));

        // Store stalled in MEMWRITE, then asynchronous reset mid-cycle.
        build(1, 3'd2, 1'b0, 0, 0, 0, 0, 3);
        void'(q.pop_back());
        play("sw_hold");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_mem_write", 32'(mem_write), 32'd0);
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_mem_req", 32'(mem_req), 32'd1);

        run("trap", 9, 3'd0, 1'b0, 0, 0, 0, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        check("trap_rst_illegal", 32'(illegal_op), 32'd0);
        check("trap_rst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_trap", 3, 3'd5, 1'b1, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised Moore-FSM control unit for the multi-cycle RV32I datapath (shared instruction/data memory, IR, OldPC, ALUOut, Data registers).
- Successor to the single-cycle decoder. Adds:
  - multi-cycle sequencing;
  - full branch set (beq/bne/blt/bge/bltu/bgeu);
  - jalr, lui and auipc;
  - a memory ready handshake with wait states;
  - illegal-opcode trapping.

Parameters:
- ALU_CTRL_W, 4, alu_control width; must be >= 4. Upper bits are driven 0.
- MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU result == 0
- lt  in  1  signed rd1 < rd2 (from ALU sub)
- ltu  in  1  unsigned rd1 < rd2
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory access active
- adr_src  out  1  0 = PC, 1 = result bus
- ir_write  out  1  load IR and OldPC
- mem_write  out  1  store strobe
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- alu_srcA  out  2  00 = PC, 01 = OldPC, 10 = rd1, 11 = zero
- alu_srcB  out  2  00 = rd2, 01 = imm, 10 = const 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- illegal_op  out  1  sticky trap flag
- state  out  4  current state (debug)

Behaviour:
- State register is reset asynchronously by rst_n low to FETCH. While rst_n is low: mem_req, ir_write, mem_write, pc_write and reg_write are all 0, and illegal_op is 0.
- All outputs are combinational from state, op, funct3 and the flags.
- Default for any output not listed in a state: 0.
- imm_src is decoded from op in every state: load/jalr/I-type = I, store = S, branch = B, jal = J, lui/auipc = U.
- Any state not listed below returns to FETCH.
- Wait-state rule: a memory state with mem_ready = 0 holds its state. It keeps mem_req and mem_write asserted and its ir_write and pc_write deasserted.

States and actions:
- FETCH (0): mem_req=1, adr_src=0, srcA=PC, srcB=4, add, result_src=10, ir_write=pc_write=mem_ready. Goes to DECODE on mem_ready.
- DECODE (1): srcA=OldPC, srcB=imm, add; this computes the branch/jal target into ALUOut.
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
  - Any other op -> TRAP.
- MEMADR (2): srcA=rd1, srcB=imm, add. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD (3): mem_req=1, adr_src=1, result_src=00. Goes to MEMWB on mem_ready.
- MEMWB (4): result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE (5): mem_req=1, mem_write=1, adr_src=1, result_src=00. Goes to FETCH on mem_ready.
- EXECR (6) / EXECI (7): srcA=rd1; srcB is rd2 in EXECR and imm in EXECI. ALU op from funct3:
  - 000: add, or sub if EXECR and funct7_5 = 1
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: srl, or sra if funct7_5 = 1
  - 110: or
  - 111: and
  - Both go to ALUWB.
- ALUWB (8): result_src=00, reg_write=1. Goes to FETCH.
- BRANCH (9): srcA=rd1, srcB=rd2, sub, result_src=00. Goes to FETCH.
  - pc_write = taken, where taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010 or 011: not taken.
- JAL (10): srcA=OldPC, srcB=4, add, result_src=00, pc_write=1. Goes to ALUWB.
- JALR (11): srcA=rd1, srcB=imm, add, result_src=10, pc_write=1. Goes to JALRL.
- JALRL (12): srcA=OldPC, srcB=4, add, result_src=10, reg_write=1. Goes to FETCH.
- LUI (13): srcA=zero, srcB=imm, add. Goes to ALUWB.
- AUIPC (14): srcA=OldPC, srcB=imm, add. Goes to ALUWB.
- TRAP (15): illegal_op=1, no enables asserted, holds until reset.

Cycle counts with mem_ready held at 1: branch 3; R/I/jal/jalr/lui/auipc/store 4; load 5. Each wait cycle adds 1.

Test Plan:
- rst_n low mid-MEMWRITE with mem_ready=0 -> state=0 immediately (asynchronous), mem_write=0; after release, FETCH asserts mem_req=1.
- add x3,x1,x2 (op 0110011, f3 000, f7_5=0), mem_ready=1 -> states 0,1,6,8,0; EXECR alu_control=0; sub (f7_5=1) -> alu_control=1; ALUWB reg_write=1.
- lw, mem_ready low 3 cycles in FETCH and 2 in MEMREAD -> ir_write pulses exactly once; MEMWB reached on cycle 10; reg_write=1 there with result_src=01.
- Branches with zero/lt/ltu sweep: bne with zero=1 -> pc_write=0; blt with lt=1 -> pc_write=1; bgeu with ltu=0 -> pc_write=1.
- jalr -> JALR: pc_write=1, result_src=10; then JALRL: reg_write=1, srcA=01, srcB=10.
- op=1111111 -> TRAP (state=15), illegal_op=1 stays high for 20 cycles with no enables asserted; rst_n low clears it.
